// File: rtl/turf_l1_pkg.sv
// turf_l1_pkg: shared types and defaults for the TURF L1 capture.
// Channel FSM encoding, default sizes and index-width helper.
package turf_l1_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DEAD = 1'b1
  } chan_st_t;

  localparam int DEF_NUM_SURFS     = 12;
  localparam int DEF_NUM_TRIG      = 4;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_HOLDOFF_BITS  = 4;
  localparam int DEF_SCALER_BITS   = 16;
  localparam int DEF_STUCK_TIMEOUT = 1024;

  function automatic int chan_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/turf_l1_chan.sv
// turf_l1_chan: one L1 channel - sync, edge, dead time, stuck, scaler.
// Live scaler is built only with TURF_L1_SCALER_EN defined.
module turf_l1_chan
  import turf_l1_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int HOLDOFF_BITS  = DEF_HOLDOFF_BITS,
  parameter int SCALER_BITS   = DEF_SCALER_BITS,
  parameter int STUCK_TIMEOUT = DEF_STUCK_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    l1,
  input  logic                    mask,
  input  logic [HOLDOFF_BITS-1:0] holdoff,
  input  logic                    latch,
  output logic                    l1_edge,
  output logic                    stuck,
  output logic [SCALER_BITS-1:0]  live
);

  localparam int HW = $clog2(STUCK_TIMEOUT + 1);
  localparam logic [HW-1:0] TMO = HW'(STUCK_TIMEOUT);

  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    s;
  logic                    p_q;
  logic                    rise;
  logic                    accept;
  chan_st_t                st_q;
  chan_st_t                st_d;
  logic [HOLDOFF_BITS-1:0] cnt_q;
  logic [HOLDOFF_BITS-1:0] cnt_d;
  logic [HW-1:0]           hcnt_q;
  logic [HW-1:0]           hcnt_inc;

  assign s        = sync_q[SYNC_STAGES-1];
  assign rise     = s & ~p_q;
  assign accept   = (st_q == ST_IDLE) & rise & ~mask & ~stuck;
  assign hcnt_inc = (hcnt_q == TMO) ? hcnt_q : hcnt_q + 1'b1;

  // synchroniser chain and one-cycle delayed copy for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      p_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], l1};
      p_q    <= s;
    end
  end

  // dead-time FSM next state; holdoff sampled only on entry to DEAD
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    case (st_q)
      ST_IDLE: begin
        if (accept && holdoff != '0) begin
          st_d  = ST_DEAD;
          cnt_d = holdoff;
        end
      end
      ST_DEAD: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == HOLDOFF_BITS'(1)) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // FSM state, dead count and registered edge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_IDLE;
      cnt_q   <= '0;
      l1_edge <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      l1_edge <= accept;
    end
  end

  // consecutive-high counter; stuck flag follows the saturated count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      stuck  <= 1'b0;
    end else if (!s) begin
      hcnt_q <= '0;
      stuck  <= 1'b0;
    end else begin
      hcnt_q <= hcnt_inc;
      stuck  <= (hcnt_inc == TMO);
    end
  end

`ifdef TURF_L1_SCALER_EN
  localparam logic [SCALER_BITS-1:0] SMAX = '1;

  // saturating live scaler; a latch restarts it at 0 or 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live <= '0;
    end else if (latch) begin
      live <= {{(SCALER_BITS-1){1'b0}}, accept};
    end else if (accept && live != SMAX) begin
      live <= live + 1'b1;
    end
  end
`else
  logic unused_latch;
  assign unused_latch = latch;
  assign live = '0;
`endif

endmodule

// File: rtl/turf_l1_capture.sv
// turf_l1_capture: L1 trigger capture into CLK125 with per-channel scalers.
// Define TURF_L1_SCALER_EN to build scalers, shadows and readout.
module turf_l1_capture
  import turf_l1_pkg::*;
#(
  parameter int NUM_SURFS     = DEF_NUM_SURFS,
  parameter int NUM_TRIG      = DEF_NUM_TRIG,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int HOLDOFF_BITS  = DEF_HOLDOFF_BITS,
  parameter int SCALER_BITS   = DEF_SCALER_BITS,
  parameter int STUCK_TIMEOUT = DEF_STUCK_TIMEOUT,
  localparam int NCH  = NUM_SURFS * NUM_TRIG,
  localparam int SELW = chan_idx_w(NCH)
) (
  input  logic                    CLK125,
  input  logic                    RST_N,
  input  logic [NCH-1:0]          L1,
  input  logic [NCH-1:0]          MASK,
  input  logic [HOLDOFF_BITS-1:0] HOLDOFF,
  output logic [NCH-1:0]          L1_EDGE,
  output logic [NUM_SURFS-1:0]    L1_ANY,
  output logic [NCH-1:0]          STUCK,
  input  logic                    SCALER_LATCH,
  input  logic [SELW-1:0]         SCALER_SEL,
  output logic [SCALER_BITS-1:0]  SCALER_DATA,
  output logic                    SCALER_VALID
);

  logic [1:0]                        rst_q;
  logic                              rst_n;
  logic [NCH-1:0][SCALER_BITS-1:0]   live_all;

  assign rst_n = rst_q[1];

  // reset asserts at once, releases two clocks after RST_N rises
  always_ff @(posedge CLK125 or negedge RST_N) begin
    if (!RST_N) rst_q <= '0;
    else        rst_q <= {rst_q[0], 1'b1};
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    turf_l1_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .HOLDOFF_BITS (HOLDOFF_BITS),
      .SCALER_BITS  (SCALER_BITS),
      .STUCK_TIMEOUT(STUCK_TIMEOUT)
    ) u_chan (
      .clk    (CLK125),
      .rst_n  (rst_n),
      .l1     (L1[c]),
      .mask   (MASK[c]),
      .holdoff(HOLDOFF),
      .latch  (SCALER_LATCH),
      .l1_edge(L1_EDGE[c]),
      .stuck  (STUCK[c]),
      .live   (live_all[c])
    );
  end

  // per-SURF OR of that SURF's edge pulses, one cycle behind
  always_ff @(posedge CLK125 or negedge rst_n) begin
    if (!rst_n) begin
      L1_ANY <= '0;
    end else begin
      for (int i = 0; i < NUM_SURFS; i++)
        L1_ANY[i] <= |L1_EDGE[i*NUM_TRIG +: NUM_TRIG];
    end
  end

`ifdef TURF_L1_SCALER_EN
  logic [NCH-1:0][SCALER_BITS-1:0] shadow_q;

  // snapshot every live scaler on a latch pulse
  always_ff @(posedge CLK125 or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q     <= '0;
      SCALER_VALID <= 1'b0;
    end else if (SCALER_LATCH) begin
      shadow_q     <= live_all;
      SCALER_VALID <= 1'b1;
    end
  end

  // registered shadow read; out-of-range index reads 0
  always_ff @(posedge CLK125 or negedge rst_n) begin
    if (!rst_n) begin
      SCALER_DATA <= '0;
    end else if (32'(SCALER_SEL) < NCH) begin
      SCALER_DATA <= shadow_q[SCALER_SEL];
    end else begin
      SCALER_DATA <= '0;
    end
  end
`else
  logic unused_scaler;
  assign unused_scaler = ^{SCALER_SEL, live_all};
  assign SCALER_DATA   = '0;
  assign SCALER_VALID  = 1'b0;
`endif

endmodule

// File: doc/turf_l1_capture.md
Name: turf_l1_capture

Overview:
Parametrised L1 trigger capture for the TURF. It takes the NUM_SURFS×NUM_TRIG single-ended L1 lines that come out of the input buffers and brings them into the CLK125 domain. For each channel it detects rising edges, applies a mask and a programmable dead time, flags stuck-high lines, and keeps latchable per-channel scalers. It sits directly after the L1 IBUFDS stage and feeds the trigger/hold logic.

Parameters:
NUM_SURFS, 12, number of SURFs
NUM_TRIG, 4, L1 lines per SURF; channel c = NUM_TRIG*surf + trig
SYNC_STAGES, 2, synchroniser flops per line (min 2)
HOLDOFF_BITS, 4, width of dead-time setting
SCALER_BITS, 16, width of each scaler
STUCK_TIMEOUT, 1024, consecutive high cycles before a line is declared stuck (≥2)

Ports:
CLK125  in  1  sole clock
RST_N  in  1  reset, asynchronous, active-low
L1  in  NUM_SURFS*NUM_TRIG  asynchronous L1 levels
MASK  in  NUM_SURFS*NUM_TRIG  1 = channel ignored (no edge, no count)
HOLDOFF  in  HOLDOFF_BITS  dead-time cycles after an accepted edge
L1_EDGE  out  NUM_SURFS*NUM_TRIG  one-cycle pulse per accepted edge
L1_ANY  out  NUM_SURFS  per-SURF OR of that SURF's L1_EDGE bits, registered
STUCK  out  NUM_SURFS*NUM_TRIG  channel held high ≥ STUCK_TIMEOUT cycles
SCALER_LATCH  in  1  pulse: snapshot and clear all scalers
SCALER_SEL  in  clog2(NUM_SURFS*NUM_TRIG)  shadow scaler read index
SCALER_DATA  out  SCALER_BITS  selected shadow scaler
SCALER_VALID  out  1  high from the first latch onward

Behaviour:
- Reset (async assert, sync release via internal 2-flop release sync): all synchronisers 0, all FSMs IDLE, L1_EDGE/L1_ANY/STUCK 0, scalers and shadows 0, SCALER_DATA 0, SCALER_VALID 0. Reset asserted mid-operation clears everything immediately, including dead-time and stuck counts.
- Sync: L1[c] passes through SYNC_STAGES flops. The last stage is s[c], and p[c] is s[c] delayed one cycle.
- Edge: rise[c] = s[c] & ~p[c]. Latency from the L1 transition to L1_EDGE is SYNC_STAGES+1 cycles. L1_ANY follows one cycle later.
- Per-channel FSM:
  - IDLE: if rise & ~MASK & ~STUCK, pulse L1_EDGE and increment the scaler. Then go to DEAD with cnt=HOLDOFF if HOLDOFF≠0; otherwise stay in IDLE.
  - DEAD: decrement cnt each cycle; at cnt==1 go to IDLE. Rises during DEAD are dropped and not counted. HOLDOFF is sampled only on entry to DEAD.
- MASK change takes effect on the next cycle. Masking a channel in DEAD does not abort the dead time.
- Stuck detection:
  - A high-counter increments while s=1 and clears when s=0.
  - STUCK[c] sets on the cycle the count reaches STUCK_TIMEOUT and clears on the first cycle s=0.
  - Stuck detection is independent of MASK.
- Scalers:
  - Saturate at 2^SCALER_BITS−1; no wrap.
  - On SCALER_LATCH every shadow takes its live value and the live counter clears. If an accepted edge coincides with SCALER_LATCH, the shadow gets the pre-edge value and the live counter loads 1.
  - SCALER_VALID sets on the first latch.
- Readout: SCALER_DATA is registered shadow[SCALER_SEL], 1-cycle latency. An out-of-range SCALER_SEL returns 0.

Optional Feature:
TURF_L1_SCALER_EN
- Defined: scalers, shadows, SCALER_DATA and SCALER_VALID behave as above.
- Undefined: no scaler or shadow logic is built. SCALER_DATA is tied to 0 and SCALER_VALID to 0. SCALER_LATCH and SCALER_SEL are ignored. Edge, dead-time and stuck behaviour are unchanged.

Decomposition:
- Package turf_l1_pkg holds:
  - FSM state encoding (IDLE, DEAD)
  - channel-index width function
  - default-parameter localparams
- One sub-module is natural: turf_l1_chan. It holds the sync chain, edge detect, FSM, stuck counter and live scaler for one channel, and is instantiated per channel in a generate loop. The top level holds the shadows, read mux and L1_ANY OR-reduction.

Test Plan:
- Reset, then single L1[5] 0→1 with HOLDOFF=0 and SYNC_STAGES=2 → L1_EDGE[5] pulses exactly once at cycle 3, and L1_ANY[1] at cycle 4.
- HOLDOFF=4 with rises on ch0 at cycles t and t+2 (low between) → one edge only. A third rise at t+6 → second edge. Latch with SCALER_SEL=0 → SCALER_DATA=2.
- MASK[7]=1 with 10 rises → no L1_EDGE[7] and scaler 7 reads 0. Unmask and apply 3 rises → reads 3.
- L1[2] held high for 1030 cycles (STUCK_TIMEOUT=1024) → STUCK[2] rises once the count reaches 1024, i.e. 3 + 1023 cycles after the L1 change, and drops 3 cycles after L1 falls. The following rise produces an edge.
- SCALER_BITS=4, 20 edges then latch → reads 15. An edge coincident with a second latch → shadow 0, and the next latch reads 1.
- RST_N pulsed low while ch3 is in DEAD → outputs clear immediately. After release, a new rise produces an edge with no residual dead time.
